clock_ratio_monitor: RTL
========================

// Module: clock_ratio_monitor
// PURPOSE
//   Consumer-side checker for a divided clock: samples mon_clk_i in the clk_i domain and measures its period in clk_i cycles.
//   Declares lock after consecutive in-tolerance periods. Flags a fault on drift, a stopped clock or a missing clock.
//   Sits next to any clock divider output; feeds status/CSR logic.
// PARAMETERS
//   EXPECTED_RATIO  8  nominal mon_clk_i period in clk_i cycles; must be >= 4
//   TOLERANCE       1  allowed |period - EXPECTED_RATIO| in clk_i cycles
//   LOCK_COUNT      4  consecutive good periods required for lock; must be >= 1
//   derived: TIMEOUT = 2*EXPECTED_RATIO; CNT_W = $clog2(TIMEOUT+1)
// PORTS
//   clk_i           in   1      reference clock
//   rst_i           in   1      reset, asynchronous, active-high
//   mon_clk_i       in   1      monitored clock, asynchronous to clk_i
//   enable_i        in   1      1 = monitor active; 0 = force IDLE
//   clear_i         in   1      pulse; leaves FAULT
//   period_o        out  CNT_W  last measured period in clk_i cycles
//   period_valid_o  out  1      1-cycle pulse when period_o updates
//   locked_o        out  1      high in LOCKED
//   error_o         out  1      high in FAULT
// BEHAVIOUR
//   - Reset (async): state=IDLE, sync flops=0, cnt=0, good_cnt=0, all outputs 0.
//   - Input path: 2-FF synchroniser plus 1 history flop. Rising edge = sync & ~hist.
//     Edge is visible 2-3 clk_i cycles after the mon_clk_i rise.
//   - cnt: +1 per clk_i cycle, saturating at TIMEOUT. On an edge: measured period = cnt+1, then cnt <= 0.
//   - good = (period >= EXPECTED_RATIO-TOLERANCE) && (period <= EXPECTED_RATIO+TOLERANCE).
//   - Timeout: cnt == TIMEOUT-1 with no edge in that cycle. An edge in that cycle wins over timeout.
//   - IDLE:    enable_i=1 -> ACQUIRE with cnt=0.
//   - ACQUIRE: first edge -> MEASURE, cnt=0, good_cnt=0, no period_valid_o. Timeout -> FAULT.
//   - MEASURE: every edge pulses period_valid_o and loads period_o.
//       good edge: good_cnt+1; on reaching LOCK_COUNT -> LOCKED.
//       bad edge: good_cnt=0, stay in MEASURE, no fault.
//       timeout -> FAULT.
//   - LOCKED:  good edge -> stay; bad edge or timeout -> FAULT.
//   - FAULT:   period_o holds its last value; clear_i=1 -> ACQUIRE with cnt=0, good_cnt=0.
//   - Outputs are registered: locked_o/error_o follow state with 1 cycle latency after the deciding edge/timeout.
//   - enable_i=0 in any state -> IDLE next cycle; locked_o=error_o=0; period_o holds.
//     enable_i=0 takes priority over clear_i and over edges.
//   - rst_i mid-operation: immediate return to reset values, no residual pulse.
// CONFIGURATION
//   CLOCK_MONITOR_STATS_EN defined adds these ports:
//     min_period_o  out CNT_W
//     max_period_o  out CNT_W
//     fault_count_o out 8, saturating at 255
//   Stats update on every period_valid_o.
//     min_period_o resets to all-ones; max_period_o resets to 0.
//     min/max are re-initialised on ACQUIRE entry.
//     fault_count_o increments on each FAULT entry and clears only on rst_i.
//   Undefined: these ports and their logic are absent; the remaining behaviour is identical.
// TESTING (defaults: EXPECTED_RATIO=8, TOLERANCE=1, LOCK_COUNT=4)
//   1. mon_clk_i = clk_i/8, enable_i=1 -> first period_valid_o on 2nd edge with period_o=8;
//      locked_o=1 one cycle after the 5th edge; error_o stays 0.
//   2. mon_clk_i = clk_i/10 -> period_o=10 on every edge, locked_o never 1, error_o stays 0.
//   3. Periods alternating 7/9 -> lock after 4 good periods; single 11 while LOCKED -> error_o=1, locked_o=0.
//   4. Locked, mon_clk_i held low -> error_o=1 after 16 clk_i cycles without edge;
//      clear_i pulse with clock restored -> locked_o=1 after 5 edges.
//   5. enable_i=1 with mon_clk_i never toggling -> error_o=1 after 16 cycles;
//      enable_i=0 -> error_o=0 next cycle; clear_i together with enable_i=0 -> IDLE.
//   6. rst_i asserted mid-LOCKED (async, between clk_i edges) -> all outputs 0 immediately;
//      with STATS_EN, fault_count_o counts 3 faults in scenario 4 repeated 3x.

Source files
------------

// File: rtl/clock_ratio_monitor.sv
// clock_ratio_monitor
//   Consumer-side checker for a divided clock. mon_clk_i is synchronised into
//   the clk_i domain, the spacing between its rising edges is measured in
//   clk_i cycles, and the result drives a small lock/fault FSM.
//
// Ports
//   clk_i           in   reference clock
//   rst_i           in   asynchronous, active-high reset
//   mon_clk_i       in   monitored clock (asynchronous to clk_i)
//   enable_i        in   1 = monitor active, 0 = force IDLE
//   clear_i         in   pulse, leaves FAULT
//   period_o        out  last measured period in clk_i cycles
//   period_valid_o  out  1-cycle pulse when period_o updates
//   locked_o        out  high while LOCKED
//   error_o         out  high while in FAULT
//
// Optional feature (macro CLOCK_MONITOR_STATS_EN)
//   min_period_o / max_period_o : extremes of periods since ACQUIRE entry
//   fault_count_o               : saturating count of FAULT entries
module clock_ratio_monitor #(
  parameter  int EXPECTED_RATIO = 8,
  parameter  int TOLERANCE      = 1,
  parameter  int LOCK_COUNT     = 4,
  localparam int TIMEOUT        = 2 * EXPECTED_RATIO,
  localparam int CNT_W          = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mon_clk_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             error_o
`ifdef CLOCK_MONITOR_STATS_EN
  ,
  output logic [CNT_W-1:0] min_period_o,
  output logic [CNT_W-1:0] max_period_o,
  output logic [7:0]       fault_count_o
`endif
);

  localparam int GC_W   = $clog2(LOCK_COUNT + 1);
  localparam int PER_LO = EXPECTED_RATIO - TOLERANCE;
  localparam int PER_HI = EXPECTED_RATIO + TOLERANCE;

  typedef enum logic [2:0] {IDLE, ACQUIRE, MEASURE, LOCKED, FAULT} state_t;

  state_t           state, state_n;
  logic             sync1, sync2, hist;
  logic [CNT_W-1:0] cnt, cnt_n, period_n, period_cur;
  logic [GC_W-1:0]  gc, gc_n, gc_inc;
  logic             pv_n, rise, good, timeout;

  // 2-FF synchroniser plus a history flop for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= mon_clk_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise       = sync2 & ~hist;
  // cnt is cleared in the edge cycle, so the edge cycle itself is the +1
  assign period_cur = cnt + CNT_W'(1);
  assign good       = (int'(period_cur) >= PER_LO) && (int'(period_cur) <= PER_HI);
  // an edge arriving in the last allowed cycle beats the timeout
  assign timeout    = (cnt == CNT_W'(TIMEOUT - 1)) && !rise;
  assign gc_inc     = gc + GC_W'(1);

  always_comb begin
    state_n  = state;
    cnt_n    = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);
    gc_n     = gc;
    pv_n     = 1'b0;
    period_n = period_o;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable_i) state_n = ACQUIRE;
      end
      ACQUIRE: begin
        // first edge only anchors the measurement
        if (rise) begin
          state_n = MEASURE;
          cnt_n   = '0;
          gc_n    = '0;
        end else if (timeout) begin
          state_n = FAULT;
        end
      end
      MEASURE: begin
        if (rise) begin
          pv_n     = 1'b1;
          period_n = period_cur;
          cnt_n    = '0;
          if (good) begin
            gc_n = gc_inc;
            if (gc_inc == GC_W'(LOCK_COUNT)) state_n = LOCKED;
          end else begin
            gc_n = '0;
          end
        end else if (timeout) begin
          state_n = FAULT;
        end
      end
      LOCKED: begin
        if (rise) begin
          pv_n     = 1'b1;
          period_n = period_cur;
          cnt_n    = '0;
          if (!good) state_n = FAULT;
        end else if (timeout) begin
          state_n = FAULT;
        end
      end
      FAULT: begin
        if (clear_i) begin
          state_n = ACQUIRE;
          cnt_n   = '0;
          gc_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // disable wins over clear and over any edge
    if (!enable_i) begin
      state_n  = IDLE;
      cnt_n    = '0;
      gc_n     = '0;
      pv_n     = 1'b0;
      period_n = period_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      gc             <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      locked_o       <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      gc             <= gc_n;
      period_o       <= period_n;
      period_valid_o <= pv_n;
      locked_o       <= (state_n == LOCKED);
      error_o        <= (state_n == FAULT);
    end
  end

`ifdef CLOCK_MONITOR_STATS_EN
  logic acq_entry, fault_entry;
  assign acq_entry   = (state_n == ACQUIRE) && (state != ACQUIRE);
  assign fault_entry = (state_n == FAULT) && (state != FAULT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_period_o  <= '1;
      max_period_o  <= '0;
      fault_count_o <= '0;
    end else begin
      if (acq_entry) begin
        min_period_o <= '1;
        max_period_o <= '0;
      end else if (pv_n) begin
        if (period_n < min_period_o) min_period_o <= period_n;
        if (period_n > max_period_o) max_period_o <= period_n;
      end
      if (fault_entry && fault_count_o != 8'hFF) fault_count_o <= fault_count_o + 8'd1;
    end
  end
`endif

endmodule
